// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data-memory port between core (0) and loader (1).
// Accept is same-cycle; load data returns 1 cycle after accept; losers and RESP cycles see ready=0. Option: ARB_FIXED_PRIORITY_EN.
module data_mem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic            req0_write,
  input  logic [XLEN-1:0] req0_address,
  input  logic [XLEN-1:0] req0_write_data,
  output logic            req0_ready,
  output logic            req0_rvalid,
  output logic [XLEN-1:0] req0_read_data,
  input  logic            req1_valid,
  input  logic            req1_write,
  input  logic [XLEN-1:0] req1_address,
  input  logic [XLEN-1:0] req1_write_data,
  output logic            req1_ready,
  output logic            req1_rvalid,
  output logic [XLEN-1:0] req1_read_data,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_write_enable,
  output logic            mem_read_enable,
  input  logic [XLEN-1:0] mem_read_data
);

  typedef enum logic {IDLE, RESP} state_e;

  state_e state_q, state_d;
  logic   prio_q, prio_d;
  logic   owner_q, owner_d;
  logic   grant;
  logic   win;
  logic   win_write;

  always_comb begin
    state_d          = state_q;
    prio_d           = prio_q;
    owner_d          = owner_q;
    grant            = 1'b0;
    win              = 1'b0;
    win_write        = 1'b0;
    req0_ready       = 1'b0;
    req1_ready       = 1'b0;
    req0_rvalid      = 1'b0;
    req1_rvalid      = 1'b0;
    req0_read_data   = '0;
    req1_read_data   = '0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;

    // Outputs are forced quiet while reset is high, including an abandoned RESP cycle.
    if (!reset) begin
      if (state_q == IDLE) begin
        if (req0_valid && req1_valid) begin
          grant = 1'b1;
          win   = prio_q;
        end else if (req0_valid || req1_valid) begin
          grant = 1'b1;
          win   = req1_valid;
        end

        if (grant) begin
          req0_ready       = ~win;
          req1_ready       = win;
          mem_address      = win ? req1_address    : req0_address;
          mem_write_data   = win ? req1_write_data : req0_write_data;
          win_write        = win ? req1_write      : req0_write;
          mem_write_enable = win_write;
          mem_read_enable  = ~win_write;
`ifdef ARB_FIXED_PRIORITY_EN
          prio_d           = 1'b0;
`else
          prio_d           = ~win;
`endif
          if (!win_write) begin
            owner_d = win;
            state_d = RESP;
          end
        end
      end else begin
        req0_rvalid    = ~owner_q;
        req1_rvalid    = owner_q;
        req0_read_data = owner_q ? '0 : mem_read_data;
        req1_read_data = owner_q ? mem_read_data : '0;
        state_d        = IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single data-memory port between two requesters: requester 0 is the core load/store path, requester 1 is the program loader/debug port.
- Uses round-robin arbitration with a valid/ready request handshake.
- Assumes a memory with synchronous read: data is available one cycle after the read is issued.
- Sits between the core/loader and data_memory, and owns the memory's address, write-data, write-enable and read-enable inputs.

Parameters:
- XLEN, 32, width of address and data buses.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a request.
- req0_write  input  1  1 = store, 0 = load (requester 0).
- req0_address  input  XLEN  byte address (requester 0).
- req0_write_data  input  XLEN  store data (requester 0).
- req0_ready  output  1  request accepted this cycle (requester 0).
- req0_rvalid  output  1  load data valid (requester 0).
- req0_read_data  output  XLEN  load data (requester 0).
- req1_valid, req1_write, req1_address, req1_write_data, req1_ready, req1_rvalid, req1_read_data: same directions, widths and meanings for requester 1.
- mem_address  output  XLEN  address to memory.
- mem_write_data  output  XLEN  store data to memory.
- mem_write_enable  output  1  memory write strobe.
- mem_read_enable  output  1  memory read strobe.
- mem_read_data  input  XLEN  memory read data, valid the cycle after mem_read_enable.

Behaviour:
- State registers: state (IDLE, RESP), prio (1 bit), owner (1 bit).
- Reset: state=IDLE, prio=0 (requester 0 favoured), owner=0.
  - All outputs are 0 during and after reset until a request arrives: readyN, rvalidN, both mem enables, and all data/address outputs.
  - Reset asserted in RESP abandons the read; no rvalid is produced.
- IDLE, winner selection (combinational):
  - Only one valid: that requester wins.
  - Both valid: requester prio wins.
  - Neither valid: no grant; mem enables 0.
- IDLE, grant cycle:
  - reqW_ready=1 for the winner only; the loser's ready=0.
  - mem_address and mem_write_data = winner's fields.
  - Winner write: mem_write_enable=1, state stays IDLE, so back-to-back writes are allowed every cycle.
  - Winner read: mem_read_enable=1, owner<=W, state<=RESP.
  - On any grant: prio<=~W.
- RESP (exactly 1 cycle):
  - req[owner]_rvalid=1 and req[owner]_read_data=mem_read_data, passed through combinationally.
  - Both readyN=0; no memory access is issued; state<=IDLE.
  - Load latency is therefore 1 cycle after accept. The port accepts at most 1 read per 2 cycles.
- Non-owner read_data outputs are 0. rvalid is never asserted for writes.
- Requester rules:
  - Holds valid and all request fields stable until ready.
  - May drop valid only after ready.
  - Arbiter behaviour is undefined if a requester changes fields while waiting.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,… No starvation beyond 1 competing transaction.
- Addresses pass through unmodified. Alignment is the memory's responsibility.

Optional Feature:
- Macro ARB_FIXED_PRIORITY_EN.
  - Defined: requester 0 always wins when both are valid. The prio register is removed or held at 0. Requester 1 can starve.
  - Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Reset, then idle: reset=1 for 2 cycles, no valids -> all readyN/rvalidN/mem enables 0 and mem_address=0 every cycle.
- Single write: req0 write, addr 0x10, data 0xDEADBEEF -> same cycle: req0_ready=1, mem_write_enable=1, mem_address=0x10, mem_write_data=0xDEADBEEF. Next cycle req0 write, addr 0x14 -> accepted immediately.
- Single read: req1 read, addr 0x10, memory returns 0xDEADBEEF -> accept cycle: req1_ready=1, mem_read_enable=1. Next cycle: req1_rvalid=1, req1_read_data=0xDEADBEEF, req0_rvalid=0, both readys 0.
- Contention: both requesters continuously valid with writes for 4 cycles after reset -> grants 0,1,0,1. Under ARB_FIXED_PRIORITY_EN -> 0,0,0,0.
- Read then contention: req0 read and req1 write both valid -> cycle 1 grant req0 read; cycle 2 RESP, req1_ready=0; cycle 3 grant req1 write.
- Reset mid-read: read accepted, reset=1 in the RESP cycle -> no rvalid in that cycle or later. The arbiter is in IDLE with prio=0 after reset is released.
